// File: rtl/mxv_pkg.sv
// Shared types and width helpers for the streaming matrix-vector dot-product engine.
package mxv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned prod_w(input int unsigned ew);
        return 2 * ew;
    endfunction

    function automatic int unsigned sum_w(input int unsigned ew, input int unsigned nu);
        return 2 * ew + clog2(nu);
    endfunction

    // Chunk count never exceeds the element count, so it shares the length width.
    function automatic int unsigned chunk_w(input int unsigned len_w);
        return len_w;
    endfunction

endpackage

// File: rtl/dot_lane_tree.sv
// Registered per-lane multiply followed by a registered adder tree; 2-cycle latency,
// masked lanes contribute zero.
module dot_lane_tree
    import mxv_pkg::*;
#(
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned NO_OF_UNITS   = 8,
    localparam int unsigned SUM_W        = sum_w(ELEMENT_WIDTH, NO_OF_UNITS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] a_data,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] b_data,
    input  logic [NO_OF_UNITS-1:0]               lane_mask,
    output logic [SUM_W-1:0]                     sum_q
);

    localparam int unsigned PROD_W = prod_w(ELEMENT_WIDTH);

    logic signed [PROD_W-1:0] prod_d [NO_OF_UNITS];
    logic signed [PROD_W-1:0] prod_q [NO_OF_UNITS];
    logic signed [SUM_W-1:0]  sum_d;

    always_comb begin
        for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
            prod_d[i] = '0;
            if (lane_mask[i]) begin
                prod_d[i] = PROD_W'($signed(a_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]))
                          * PROD_W'($signed(b_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NO_OF_UNITS); i++) prod_q[i] <= '0;
            sum_q <= '0;
        end else begin
            for (int i = 0; i < int'(NO_OF_UNITS); i++) prod_q[i] <= prod_d[i];
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/dot_stream_mxv_ctrl.sv
// Streaming dot-product controller: NUM_ROWS dot products of programmable length with
// tail masking and valid/ready result output. Define SATURATE_EN to clamp results.
module dot_stream_mxv_ctrl
    import mxv_pkg::*;
#(
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned NO_OF_UNITS   = 8,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter int unsigned ROW_WIDTH     = 16,
    parameter int unsigned ACC_WIDTH     = 2*ELEMENT_WIDTH+16,
    parameter int unsigned FRAC_BITS     = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [LEN_WIDTH-1:0]                 vec_len,
    input  logic [ROW_WIDTH-1:0]                 num_rows,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] a_data,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] b_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [ELEMENT_WIDTH-1:0]             res_data,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic [chunk_w(LEN_WIDTH)-1:0]        chunk_cnt
);

    localparam int unsigned SUM_W = sum_w(ELEMENT_WIDTH, NO_OF_UNITS);
    localparam int unsigned CNT_W = chunk_w(LEN_WIDTH);

    state_t                        state_q, state_d;
    logic [LEN_WIDTH-1:0]          vec_len_q, vec_len_d;
    logic [ROW_WIDTH-1:0]          rows_left_q, rows_left_d;
    logic [LEN_WIDTH-1:0]          elems_left_q, elems_left_d;
    logic [CNT_W-1:0]              chunk_cnt_q, chunk_cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          drain_q, drain_d;
    logic [ELEMENT_WIDTH-1:0]      res_data_q, res_data_d;
    logic                          res_valid_q, res_valid_d;
    logic                          in_ready_q, in_ready_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic                          fire_c;
    logic [NO_OF_UNITS-1:0]        lane_mask_c;
    logic [LEN_WIDTH-1:0]          step_c;
    logic [SUM_W-1:0]              tree_sum;

    // Shift then either truncate or clamp to the element range.
    function automatic logic [ELEMENT_WIDTH-1:0] fmt(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
`ifdef SATURATE_EN
        logic signed [ACC_WIDTH-1:0] max_v;
        logic signed [ACC_WIDTH-1:0] min_v;
        max_v = ACC_WIDTH'({1'b0, {(ELEMENT_WIDTH-1){1'b1}}});
        min_v = ~max_v;
`endif
        s = a >>> FRAC_BITS;
`ifdef SATURATE_EN
        if (s > max_v) return {1'b0, {(ELEMENT_WIDTH-1){1'b1}}};
        if (s < min_v) return {1'b1, {(ELEMENT_WIDTH-1){1'b0}}};
`endif
        return s[ELEMENT_WIDTH-1:0];
    endfunction

    assign fire_c = in_valid && in_ready_q && (state_q == RUN);
    assign step_c = (elems_left_q < LEN_WIDTH'(NO_OF_UNITS)) ? elems_left_q
                                                             : LEN_WIDTH'(NO_OF_UNITS);

    always_comb begin
        lane_mask_c = '0;
        for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
            lane_mask_c[i] = fire_c && (elems_left_q > LEN_WIDTH'(i));
        end
    end

    dot_lane_tree #(
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .NO_OF_UNITS   (NO_OF_UNITS)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .a_data    (a_data),
        .b_data    (b_data),
        .lane_mask (lane_mask_c),
        .sum_q     (tree_sum)
    );

    always_comb begin
        state_d      = state_q;
        vec_len_d    = vec_len_q;
        rows_left_d  = rows_left_q;
        elems_left_d = elems_left_q;
        chunk_cnt_d  = chunk_cnt_q;
        acc_d        = acc_q + ACC_WIDTH'($signed(tree_sum));
        drain_d      = drain_q;
        res_data_d   = res_data_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_len_d    = vec_len;
                    rows_left_d  = (num_rows == '0) ? ROW_WIDTH'(1) : num_rows;
                    elems_left_d = vec_len;
                    chunk_cnt_d  = '0;
                    acc_d        = '0;
                    state_d      = (vec_len == '0) ? OUT : RUN;
                end
            end
            RUN: begin
                if (fire_c) begin
                    elems_left_d = elems_left_q - step_c;
                    chunk_cnt_d  = chunk_cnt_q + CNT_W'(1);
                    if (elems_left_d == '0) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    if (rows_left_q > ROW_WIDTH'(1)) begin
                        rows_left_d  = rows_left_q - ROW_WIDTH'(1);
                        acc_d        = '0;
                        elems_left_d = vec_len_q;
                        chunk_cnt_d  = '0;
                        state_d      = (vec_len_q == '0) ? OUT : RUN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == RUN);
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == OUT);
        // Capture a fresh result on every entry into OUT; hold it while stalled.
        if ((state_d == OUT) && ((state_q != OUT) || res_ready)) begin
            res_data_d = fmt(acc_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vec_len_q    <= '0;
            rows_left_q  <= '0;
            elems_left_q <= '0;
            chunk_cnt_q  <= '0;
            acc_q        <= '0;
            drain_q      <= 1'b0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_len_q    <= vec_len_d;
            rows_left_q  <= rows_left_d;
            elems_left_q <= elems_left_d;
            chunk_cnt_q  <= chunk_cnt_d;
            acc_q        <= acc_d;
            drain_q      <= drain_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign chunk_cnt = chunk_cnt_q;

endmodule

// File: tb/tb_dot_stream_mxv_ctrl.sv
// Directed bench for dot_stream_mxv_ctrl with 4 lanes of 16-bit elements.
module tb_dot_stream_mxv_ctrl;

    localparam int unsigned EW = 16;
    localparam int unsigned NU = 4;
    localparam int unsigned LW = 16;
    localparam int unsigned RW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [LW-1:0]     vec_len = '0;
    logic [RW-1:0]     num_rows = '0;
    logic [NU*EW-1:0]  a_data = '0;
    logic [NU*EW-1:0]  b_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [EW-1:0]     res_data;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [LW-1:0]     chunk_cnt;

    int checks = 0;
    int passed = 0;

    dot_stream_mxv_ctrl #(
        .ELEMENT_WIDTH (EW),
        .NO_OF_UNITS   (NU),
        .LEN_WIDTH     (LW),
        .ROW_WIDTH     (RW),
        .ACC_WIDTH     (2*EW+16),
        .FRAC_BITS     (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .vec_len   (vec_len),
        .num_rows  (num_rows),
        .a_data    (a_data),
        .b_data    (b_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .chunk_cnt (chunk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0]    len;
        int               nbeats;
        logic [NU*EW-1:0] a0;
        logic [NU*EW-1:0] a1;
        logic [NU*EW-1:0] b0;
        logic [NU*EW-1:0] b1;
        logic [EW-1:0]    exp_res;
        logic [LW-1:0]    exp_chunks;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [NU*EW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic start_job(input logic [LW-1:0] len, input logic [RW-1:0] rows);
        @(negedge clk);
        vec_len  = len;
        num_rows = rows;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic drive_beat(input logic [NU*EW-1:0] a, input logic [NU*EW-1:0] b);
        int g;
        @(negedge clk);
        in_valid = 1'b1;
        a_data   = a;
        b_data   = b;
        g = 0;
        while (!in_ready && g < 20) begin
            @(posedge clk);
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("beat_accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
    endtask

    // Called right after the last beat's accepting edge: checks drain latency and result.
    task automatic finish_after_last(input string nm, input logic [EW-1:0] exp_res,
                                     input logic [LW-1:0] exp_chunks);
        @(negedge clk);
        in_valid = 1'b0;
        check({nm, "_in_ready_drop"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_valid_early"}, 64'(res_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_valid_3cyc"}, 64'(res_valid), 64'd1);
        check({nm, "_res"}, 64'(res_data), 64'(exp_res));
        check({nm, "_chunks"}, 64'(chunk_cnt), 64'(exp_chunks));
    endtask

    task automatic handshake(input string nm, input logic exp_done);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check({nm, "_done"}, 64'(done), 64'(exp_done));
        check({nm, "_valid_fall"}, 64'(res_valid), 64'd0);
        if (exp_done) check({nm, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        tbl[0] = '{16'd8, 2, pk(1,2,3,4), pk(5,6,7,8), pk(2,2,2,2), pk(2,2,2,2), 16'd72, 16'd2};
        tbl[1] = '{16'd6, 2, pk(1,2,3,4), pk(5,6,7,8), pk(1,1,1,1), pk(1,1,1,1), 16'd21, 16'd2};
`ifdef SATURATE_EN
        tbl[2] = '{16'd8, 2, pk(32767,32767,32767,32767), pk(32767,32767,32767,32767),
                   pk(32767,32767,32767,32767), pk(32767,32767,32767,32767), 16'h7FFF, 16'd2};
`else
        tbl[2] = '{16'd8, 2, pk(32767,32767,32767,32767), pk(32767,32767,32767,32767),
                   pk(32767,32767,32767,32767), pk(32767,32767,32767,32767), 16'h0008, 16'd2};
`endif
        tbl[3] = '{16'd4, 1, pk(-1,-2,-3,-4), '0, pk(3,3,3,3), '0, 16'hFFE2, 16'd1};
        tbl[4] = '{16'd1, 1, pk(5,99,99,99), '0, pk(7,7,7,7), '0, 16'd35, 16'd1};
        tbl[5] = '{16'd5, 2, pk(1,2,3,4), pk(5,6,7,8), pk(1,1,1,1), pk(1,1,1,1), 16'd15, 16'd2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_chunk_cnt", 64'(chunk_cnt), 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            start_job(tbl[k].len, 16'd1);
            drive_beat(tbl[k].a0, tbl[k].b0);
            if (tbl[k].nbeats > 1) drive_beat(tbl[k].a1, tbl[k].b1);
            finish_after_last($sformatf("vec%0d", k), tbl[k].exp_res, tbl[k].exp_chunks);
            handshake($sformatf("vec%0d", k), 1'b1);
        end

        // Bubbles between beats plus a stray start pulse mid-job
        start_job(16'd8, 16'd1);
        drive_beat(pk(1,2,3,4), pk(2,2,2,2));
        @(negedge clk);
        in_valid = 1'b0;
        vec_len  = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        drive_beat(pk(5,6,7,8), pk(2,2,2,2));
        finish_after_last("bubble", 16'd72, 16'd2);
        handshake("bubble", 1'b1);

        // Backpressure across two rows
        start_job(16'd4, 16'd2);
        drive_beat(pk(1,2,3,4), pk(1,1,1,1));
        finish_after_last("bp_row0", 16'd10, 16'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", c), 64'(res_valid), 64'd1);
            check($sformatf("bp_hold_data%0d", c), 64'(res_data), 64'd10);
            check($sformatf("bp_hold_in_ready%0d", c), 64'(in_ready), 64'd0);
        end
        handshake("bp_row0", 1'b0);
        check("bp_row1_in_ready", 64'(in_ready), 64'd1);
        check("bp_row1_chunk_clr", 64'(chunk_cnt), 64'd0);
        drive_beat(pk(2,2,2,2), pk(3,3,3,3));
        finish_after_last("bp_row1", 16'd24, 16'd1);
        handshake("bp_row1", 1'b1);

        // Asynchronous reset in RUN
        start_job(16'd8, 16'd1);
        drive_beat(pk(1,2,3,4), pk(1,1,1,1));
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_chunk_cnt", 64'(chunk_cnt), 64'd0);
        check("arst_res_data", 64'(res_data), 64'd0);
        check("arst_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Zero length: result 0 straight away, no beats consumed
        in_valid = 1'b1;
        a_data   = pk(9,9,9,9);
        b_data   = pk(9,9,9,9);
        start_job(16'd0, 16'd1);
        @(negedge clk);
        check("zero_res_valid", 64'(res_valid), 64'd1);
        check("zero_res_data", 64'(res_data), 64'd0);
        check("zero_in_ready", 64'(in_ready), 64'd0);
        check("zero_chunk_cnt", 64'(chunk_cnt), 64'd0);
        handshake("zero", 1'b1);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
